// File: rtl/button_conditioner_if.sv
// Signal bundle between the board push-button pin and its conditioned outputs.
// The master drives the raw pin; the slave (the conditioner) drives the rest.
interface button_conditioner_if;
  logic BTN;
  logic btn_level;
  logic btn_press;
  logic btn_release;
  logic long_press;
  logic reset_req;

  modport master (
    output BTN,
    input  btn_level,
    input  btn_press,
    input  btn_release,
    input  long_press,
    input  reset_req
  );

  modport slave (
    input  BTN,
    output btn_level,
    output btn_press,
    output btn_release,
    output long_press,
    output reset_req
  );
endinterface

// File: rtl/button_conditioner.sv
// Synchronises and debounces one raw push-button and derives press/release/long-press
// pulses plus a stretched reset request for the downstream core.
module button_conditioner #(
  parameter bit ACTIVE_LOW      = 1'b0,
  parameter int DEBOUNCE_CYCLES = 16384,
  parameter int LONG_CYCLES     = 65536,
  parameter int RESET_PULSE     = 16
) (
  input logic CLK,
  input logic RESET,
  button_conditioner_if.slave bus
);

  localparam int DB_W    = $clog2(DEBOUNCE_CYCLES + 1);
  localparam int HOLD_W  = $clog2(LONG_CYCLES + 1);
  localparam int PULSE_W = $clog2(RESET_PULSE + 1);

  localparam logic [DB_W-1:0]    DB_MAX     = DB_W'(DEBOUNCE_CYCLES);
  localparam logic [DB_W-1:0]    DB_ONE     = DB_W'(1);
  localparam logic [HOLD_W-1:0]  HOLD_MAX   = HOLD_W'(LONG_CYCLES);
  localparam logic [HOLD_W-1:0]  HOLD_ARM   = HOLD_W'(LONG_CYCLES - 1);
  localparam logic [HOLD_W-1:0]  HOLD_ONE   = HOLD_W'(1);
  localparam logic [PULSE_W-1:0] PULSE_LOAD = PULSE_W'(RESET_PULSE);
  localparam logic [PULSE_W-1:0] PULSE_ONE  = PULSE_W'(1);

  typedef enum logic [1:0] {
    RELEASED,
    PRESS_WAIT,
    PRESSED,
    RELEASE_WAIT
  } state_t;

  logic               w_n;
  logic               r_sync1;
  logic               r_btn_s;
  state_t             r_state;
  logic [DB_W-1:0]    r_cnt;
  logic               r_level;
  logic               r_press;
  logic               r_release;
  logic [HOLD_W-1:0]  r_hold;
  logic               r_long;
  logic [PULSE_W-1:0] r_pulse;

  // Pressed always reads 1 from here on, whatever the pin polarity.
  assign w_n = bus.BTN ^ ACTIVE_LOW;

  // NOTE: sequential state uses non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_sync1 <= 1'b0;
      r_btn_s <= 1'b0;
    end else begin
      r_sync1 <= w_n;
      r_btn_s <= r_sync1;
    end
  end

  // Debounce: a new value must be seen DEBOUNCE_CYCLES+1 consecutive samples.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_state   <= RELEASED;
      r_cnt     <= '0;
      r_level   <= 1'b0;
      r_press   <= 1'b0;
      r_release <= 1'b0;
    end else begin
      r_press   <= 1'b0;
      r_release <= 1'b0;
      unique case (r_state)
        RELEASED: begin
          if (r_btn_s) begin
            r_state <= PRESS_WAIT;
            r_cnt   <= DB_ONE;
          end
        end
        PRESS_WAIT: begin
          if (!r_btn_s) begin
            r_state <= RELEASED;
            r_cnt   <= '0;
          end else if (r_cnt == DB_MAX) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
            r_level <= 1'b1;
            r_press <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        PRESSED: begin
          if (!r_btn_s) begin
            r_state <= RELEASE_WAIT;
            r_cnt   <= DB_ONE;
          end
        end
        RELEASE_WAIT: begin
          if (r_btn_s) begin
            r_state <= PRESSED;
            r_cnt   <= '0;
          end else if (r_cnt == DB_MAX) begin
            r_state   <= RELEASED;
            r_cnt     <= '0;
            r_level   <= 1'b0;
            r_release <= 1'b1;
          end else begin
            r_cnt <= r_cnt + DB_ONE;
          end
        end
        // NOTE: an explicit default recovers from any illegal encoding instead of holding state.
        default: begin
          r_state <= RELEASED;
          r_cnt   <= '0;
          r_level <= 1'b0;
        end
      endcase
    end
  end

  // Hold counter saturates, so long_press fires once per press and re-arms only on release.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_hold <= '0;
      r_long <= 1'b0;
    end else begin
      r_long <= 1'b0;
      if (!r_level) begin
        r_hold <= '0;
      end else if (r_hold != HOLD_MAX) begin
        r_hold <= r_hold + HOLD_ONE;
        if (r_hold == HOLD_ARM) begin
          r_long <= 1'b1;
        end
      end
    end
  end

  // A running pulse is never reloaded, so it is neither extended nor cut short.
  always_ff @(posedge CLK) begin
    if (RESET) begin
      r_pulse <= '0;
    end else if (r_pulse != '0) begin
      r_pulse <= r_pulse - PULSE_ONE;
    end else if (r_long) begin
      r_pulse <= PULSE_LOAD;
    end
  end

  assign bus.btn_level   = r_level;
  assign bus.btn_press   = r_press;
  assign bus.btn_release = r_release;
  assign bus.long_press  = r_long;
  assign bus.reset_req   = (r_pulse != '0);

endmodule

// File: tb/tb_button_conditioner.sv
// Scoreboard bench: an active-high and an active-low instance share stimulus and are
// compared every cycle against one behavioural model, plus directed timing checks.
module tb_button_conditioner;

  localparam int DEB = 4;
  localparam int LNG = 10;
  localparam int RP  = 3;

  logic clk;
  logic rst;

  button_conditioner_if ifa ();
  button_conditioner_if ifb ();

  assign ifb.BTN = ~ifa.BTN;

  button_conditioner #(
    .ACTIVE_LOW(1'b0), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .RESET_PULSE(RP)
  ) dut_hi (
    .CLK(clk), .RESET(rst), .bus(ifa)
  );

  button_conditioner #(
    .ACTIVE_LOW(1'b1), .DEBOUNCE_CYCLES(DEB), .LONG_CYCLES(LNG), .RESET_PULSE(RP)
  ) dut_lo (
    .CLK(clk), .RESET(rst), .bus(ifb)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int total = 0;
  int bad   = 0;

  task automatic check(input string tag, input int got, input int exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  // Behavioural reference: a two-stage delay line feeding a streak detector.
  logic m_s1, m_s2, m_level, m_press, m_rel, m_long;
  int   m_streak, m_hold, m_pulse;
  logic [4:0] exp_q[$];

  task automatic model_step(input logic n, input logic r);
    logic s, level_old, long_old;
    int   hold_old;
    if (r) begin
      m_s1 = 0; m_s2 = 0; m_level = 0; m_press = 0; m_rel = 0; m_long = 0;
      m_streak = 0; m_hold = 0; m_pulse = 0;
    end else begin
      s         = m_s2;
      m_s2      = m_s1;
      m_s1      = n;
      level_old = m_level;
      long_old  = m_long;
      hold_old  = m_hold;
      m_press   = 0;
      m_rel     = 0;
      if (s != m_level) begin
        m_streak++;
        if (m_streak == DEB + 1) begin
          m_level  = s;
          m_press  = s;
          m_rel    = !s;
          m_streak = 0;
        end
      end else begin
        m_streak = 0;
      end
      m_hold  = level_old ? ((hold_old + 1 > LNG) ? LNG : hold_old + 1) : 0;
      m_long  = (m_hold == LNG) && (hold_old != LNG);
      m_pulse = (m_pulse != 0) ? m_pulse - 1 : (long_old ? RP : 0);
    end
    exp_q.push_back({m_level, m_press, m_rel, m_long, (m_pulse != 0)});
  endtask

  // Per-segment event tracking on the active-high instance.
  int t, first_press, first_rel, first_long, first_req;
  int n_press, n_rel, n_long, n_req, n_lvl;

  task automatic seg_start();
    t = 0;
    first_press = -1; first_rel = -1; first_long = -1; first_req = -1;
    n_press = 0; n_rel = 0; n_long = 0; n_req = 0; n_lvl = 0;
  endtask

  function automatic logic [4:0] pack_a();
    return {ifa.btn_level, ifa.btn_press, ifa.btn_release, ifa.long_press, ifa.reset_req};
  endfunction

  function automatic logic [4:0] pack_b();
    return {ifb.btn_level, ifb.btn_press, ifb.btn_release, ifb.long_press, ifb.reset_req};
  endfunction

  task automatic step(input logic b, input logic r);
    logic [4:0] ga, gb, e;
    ifa.BTN = b;
    rst     = r;
    model_step(b, r);
    @(posedge clk);
    @(negedge clk);
    ga = pack_a();
    gb = pack_b();
    e  = exp_q.pop_front();
    check("sb_hi", int'(ga), int'(e));
    check("sb_lo", int'(gb), int'(e));
    if (ga[4]) n_lvl++;
    if (ga[3]) begin n_press++; if (first_press < 0) first_press = t; end
    if (ga[2]) begin n_rel++;   if (first_rel   < 0) first_rel   = t; end
    if (ga[1]) begin n_long++;  if (first_long  < 0) first_long  = t; end
    if (ga[0]) begin n_req++;   if (first_req   < 0) first_req   = t; end
    t++;
  endtask

  task automatic run(input logic b, input int n);
    for (int i = 0; i < n; i++) step(b, 1'b0);
  endtask

  initial begin
    rst     = 1'b1;
    ifa.BTN = 1'b0;
    seg_start();

    // Reset held with the button pressed, then press, long press and reset request.
    step(1'b1, 1'b1);
    check("rst_hold0", int'(pack_a()), 0);
    step(1'b1, 1'b1);
    check("rst_hold1", int'(pack_a()), 0);
    seg_start();
    run(1'b1, 20);
    check("press_latency", first_press, DEB + 2);
    check("press_count", n_press, 1);
    check("long_time", first_long, DEB + 2 + LNG);
    check("long_count", n_long, 1);
    check("req_start", first_req, DEB + 3 + LNG);
    check("req_len", n_req, RP);

    // Release while reset_req is high.
    step(1'b1, 1'b1);
    seg_start();
    run(1'b1, 17);
    check("long_time2", first_long, 16);
    seg_start();
    run(1'b0, 10);
    check("req_len_rel", n_req, RP);
    check("req_start_rel", first_req, 0);
    check("release_latency", first_rel, DEB + 2);
    check("release_count", n_rel, 1);

    // Bounce shorter than the debounce window.
    seg_start();
    run(1'b1, 3);
    run(1'b0, 1);
    run(1'b1, 3);
    run(1'b0, 8);
    check("bounce_press", n_press, 0);
    check("bounce_level", n_lvl, 0);

    // Reset in the middle of PRESS_WAIT.
    seg_start();
    run(1'b1, 4);
    step(1'b1, 1'b1);
    check("rst_mid_wait", int'(pack_a()), 0);
    seg_start();
    run(1'b1, 8);
    check("press_after_rst", first_press, DEB + 2);

    // Reset in the middle of the reset_req pulse.
    step(1'b1, 1'b1);
    seg_start();
    run(1'b1, 18);
    check("req_live", n_req, 1);
    step(1'b1, 1'b1);
    check("rst_mid_req", int'(pack_a()), 0);
    seg_start();
    run(1'b1, 8);
    check("press_after_rst2", first_press, DEB + 2);
    check("req_killed", n_req, 0);
    run(1'b0, 10);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
